cnn_accelerator_acc_requant: RTL
================================

// Module: cnn_accelerator_acc_requant
// PURPOSE
//  Downstream of the signed product multiplier in the conv datapath. Consumes a stream of
//  signed products and sums cfg_taps products into one output pixel. Adds the bias, applies
//  a rounding arithmetic right shift, optional ReLU, and saturation to an OUT_WIDTH activation.
//  Each result is presented on a valid/ready output toward the line buffer / writeback stage.
// PARAMETERS
//  PROD_WIDTH   26  signed product width (multiplier dout)
//  ACC_WIDTH    32  signed accumulator width; must be >= PROD_WIDTH
//  OUT_WIDTH     8  signed output activation width
//  TAPS_WIDTH    8  width of tap-count config
//  SHIFT_WIDTH   5  width of requant shift config (0..ACC_WIDTH-1)
// PORTS
//  ap_clk       in   1            clock, all logic on rising edge
//  ap_rst_n     in   1            synchronous active-low reset
//  cfg_taps     in   TAPS_WIDTH   products per output; 0 is treated as 1
//  cfg_shift    in   SHIFT_WIDTH  requant right-shift amount
//  cfg_relu_en  in   1            1: clamp negative results to 0
//  cfg_bias     in   ACC_WIDTH    signed bias added once per output
//  in_valid     in   1            in_prod valid
//  in_ready     out  1            block accepts in_prod this cycle
//  in_prod      in   PROD_WIDTH   signed product
//  out_valid    out  1            out_data valid
//  out_ready    in   1            consumer accepts out_data
//  out_data     out  OUT_WIDTH    signed activation
//  out_sat      out  1            accumulator or output saturated for this pixel
//  busy         out  1            window in progress or result pending
// BEHAVIOUR
//  Reset (ap_rst_n=0 at edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, busy=0.
//  The reset is honoured mid-window and mid-EMIT. The partial sum is discarded and no output is emitted.
//  Accept = in_valid & in_ready. in_ready=1 in IDLE/ACCUM, 0 in EMIT.
//  FSM:
//   IDLE : on accept, latch cfg_* (taps_q=max(cfg_taps,1)), acc=sat(bias+sext(prod)),
//          cnt=1. If taps_q==1, go to EMIT, else go to ACCUM.
//   ACCUM: on accept, acc=sat(acc+sext(prod)) and cnt++. Once cnt reaches taps_q -> EMIT.
//          No accept means hold. cfg_* changes mid-window are ignored.
//   EMIT : out_valid=1 with out_data/out_sat stable. On out_ready, out_valid drops -> IDLE.
//  Latency: out_valid rises the cycle after the last product is accepted.
//  Throughput: taps_q+1 cycles per pixel minimum (one bubble).
//  Accumulator: saturating signed add, clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   Any clamp sets a sticky per-window sat flag.
//  Requant is computed combinationally from acc on entry to EMIT and registered into out_data:
//   r = (shift==0) ? acc : (acc + 2^(shift-1)) >>> shift. The rounding add is done in
//   ACC_WIDTH+1 bits so it cannot overflow.
//   If relu_en and r<0, then r=0.
//   Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. A clamp here also sets out_sat.
//  busy=1 in ACCUM and EMIT. In IDLE, busy goes to 1 on the cycle after the first accept.
//  in_valid while in EMIT is back-pressured, not dropped. Products never merge across pixels.
// STRUCTURE
//  Shared package cnn_accel_pkg: state enum {IDLE,ACCUM,EMIT}, ACC_MAX/ACC_MIN, OUT_MAX/OUT_MIN
//  constants, and the sat_add function.
//  One sub-module, cnn_accelerator_requant: combinational shift/round/ReLU/clamp with
//  acc, shift, relu_en in and data, sat out. Counter and FSM stay in the top module.
// TESTING
//  T1 taps=3, bias=10, shift=0, relu=0, prods 5,-2,7 -> one out_data=20, out_sat=0,
//     out_valid 1 cycle after 3rd accept.
//  T2 taps=2, bias=0, shift=2, prods 3,3 (acc=6) -> out_data=2 (round 6/4=1.5 up);
//     prods -3,-3 -> out_data=-1.
//  T3 relu=1, taps=1, bias=-50, prod 0, shift=0 -> out_data=0.
//     relu=0, same stimulus -> out_data=-50.
//  T4 taps=2, shift=0, prods 1000,1000 -> out_data=127, out_sat=1.
//     ACC_WIDTH=26, prods 2^25-1 twice -> acc clamps, out_sat=1.
//  T5 out_ready=0 for 5 cycles in EMIT -> out_valid/out_data held and in_ready=0.
//     Inputs stall, then resume correctly with no lost product.
//  T6 reset pulse after 2 of 4 products -> no output, all outputs at reset values.
//     Next window taps=1, prod=9, bias=0 -> out_data=9. Also cfg_taps=0 -> behaves as 1.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// Shared types, default widths and saturation helpers for the conv-datapath
// accumulate/requantise stage.
package cnn_accel_pkg;

  localparam int DEF_PROD_WIDTH  = 26;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_OUT_WIDTH   = 8;
  localparam int DEF_TAPS_WIDTH  = 8;
  localparam int DEF_SHIFT_WIDTH = 5;

  localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Operands arrive sign-extended to 64 bits so the raw sum cannot wrap;
  // the result is clamped to the signed range of a w-bit accumulator.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/cnn_accelerator_acc_requant_if.sv
// Product input stream and activation output stream of the accumulate/requant stage.
interface cnn_accelerator_acc_requant_if #(
  parameter int PROD_WIDTH = 26,
  parameter int OUT_WIDTH  = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [PROD_WIDTH-1:0] in_prod;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/cnn_accelerator_requant.sv
// Combinational requantiser: rounding arithmetic right shift, optional ReLU,
// and saturation of the accumulator to an OUT_WIDTH activation.
module cnn_accelerator_requant
  import cnn_accel_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   i_acc,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  input  logic                          i_relu_en,
  output logic signed [OUT_WIDTH-1:0]   o_data,
  output logic                          o_sat
);

  localparam logic signed [ACC_WIDTH:0] L_OUT_MAX = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] L_OUT_MIN = (ACC_WIDTH+1)'(-(2 ** (OUT_WIDTH-1)));

  // One extra bit of headroom so adding the half-LSB rounding term cannot overflow.
  logic signed [ACC_WIDTH:0] w_wide;
  logic signed [ACC_WIDTH:0] w_rnd;
  logic signed [ACC_WIDTH:0] w_r;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the if/else chain leaves a value unassigned and infers a latch.
  always_comb begin
    w_wide = {i_acc[ACC_WIDTH-1], i_acc};
    w_rnd  = '0;
    o_sat  = 1'b0;
    if (i_shift != '0) w_rnd = (ACC_WIDTH+1)'(1) << (i_shift - 1'b1);
    w_r = (w_wide + w_rnd) >>> i_shift;
    if (i_relu_en && (w_r < 0)) w_r = '0;
    if (w_r > L_OUT_MAX) begin
      o_data = L_OUT_MAX[OUT_WIDTH-1:0];
      o_sat  = 1'b1;
    end else if (w_r < L_OUT_MIN) begin
      o_data = L_OUT_MIN[OUT_WIDTH-1:0];
      o_sat  = 1'b1;
    end else begin
      o_data = w_r[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cnn_accelerator_acc_requant.sv
// Sums cfg_taps signed products plus bias into one pixel, then requantises it
// and holds the activation on a valid/ready output until it is taken.
module cnn_accelerator_acc_requant
  import cnn_accel_pkg::*;
#(
  parameter int PROD_WIDTH  = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int TAPS_WIDTH  = DEF_TAPS_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic        [TAPS_WIDTH-1:0]  cfg_taps,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          cfg_relu_en,
  input  logic signed [ACC_WIDTH-1:0]   cfg_bias,
  output logic                          busy,
  cnn_accelerator_acc_requant_if.slave  s_if
);

  state_t                        r_state, w_state_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc, w_acc_nxt;
  logic                          r_sat, w_sat_nxt;
  logic        [TAPS_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        [TAPS_WIDTH-1:0]  r_taps, w_taps_cfg;
  logic        [SHIFT_WIDTH-1:0] r_shift, w_shift_sel;
  logic                          r_relu_en, w_relu_sel;
  logic signed [OUT_WIDTH-1:0]   r_out_data, w_q_data;
  logic                          r_out_sat, w_q_sat;
  logic                          w_idle, w_accept, w_add_clamped;
  logic signed [PROD_WIDTH-1:0]  w_prod;
  logic signed [63:0]            w_add_a, w_add_b, w_add_val;

  assign w_idle         = (r_state == IDLE);
  assign s_if.in_ready  = (r_state != EMIT);
  assign s_if.out_valid = (r_state == EMIT);
  assign s_if.out_data  = r_out_data;
  assign s_if.out_sat   = r_out_sat;
  assign busy           = !w_idle;

  assign w_accept   = s_if.in_valid & s_if.in_ready;
  assign w_prod     = s_if.in_prod;
  assign w_taps_cfg = (cfg_taps == '0) ? TAPS_WIDTH'(1) : cfg_taps;
  assign w_cnt_inc  = r_cnt + 1'b1;

  // The first product of a window starts from the bias, later ones from the running sum.
  assign w_add_a       = w_idle ? 64'(cfg_bias) : 64'(r_acc);
  assign w_add_b       = 64'(w_prod);
  assign w_add_val     = sat_add(w_add_a, w_add_b, ACC_WIDTH);
  assign w_add_clamped = (w_add_val != (w_add_a + w_add_b));

  // In IDLE the config is latched on the same edge, so a one-tap window must use it live.
  assign w_shift_sel = w_idle ? cfg_shift   : r_shift;
  assign w_relu_sel  = w_idle ? cfg_relu_en : r_relu_en;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_acc_nxt   = w_add_val[ACC_WIDTH-1:0];
        w_sat_nxt   = w_add_clamped;
        w_cnt_nxt   = TAPS_WIDTH'(1);
        w_state_nxt = (w_taps_cfg == TAPS_WIDTH'(1)) ? EMIT : ACCUM;
      end
      ACCUM: if (w_accept) begin
        w_acc_nxt = w_add_val[ACC_WIDTH-1:0];
        w_sat_nxt = r_sat | w_add_clamped;
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == r_taps) w_state_nxt = EMIT;
      end
      EMIT: if (s_if.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requantise the value the accumulator is about to hold, so the result is
  // registered on the same edge that enters EMIT.
  cnn_accelerator_requant #(
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_requant (
    .i_acc     (w_acc_nxt),
    .i_shift   (w_shift_sel),
    .i_relu_en (w_relu_sel),
    .o_data    (w_q_data),
    .o_sat     (w_q_sat)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_cnt      <= '0;
      r_taps     <= '0;
      r_shift    <= '0;
      r_relu_en  <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_idle && w_accept) begin
        r_taps    <= w_taps_cfg;
        r_shift   <= cfg_shift;
        r_relu_en <= cfg_relu_en;
      end
      if ((r_state != EMIT) && (w_state_nxt == EMIT)) begin
        r_out_data <= w_q_data;
        r_out_sat  <= w_sat_nxt | w_q_sat;
      end
    end
  end

endmodule
